stage_memory: RTL and testbench
===============================

Name: stage_memory

Overview:
Pipeline stage directly downstream of the execute stage. It takes ALU results and memory requests from execute and drives a valid/ready data-memory bus. It returns load data, or passes ALU results through, to the writeback stage as a registered register-write pair. It stalls the upstream pipeline while a memory access is outstanding and provides a forwarding tap for the instruction it currently holds.

Parameters:
ADDR_W, 32, width of data-memory address
DATA_W, 32, width of data word and register value
REG_W, 4, register-address width; address 0 means no write (bubble)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
stall_in  in  1  stall request from the downstream (writeback) stage
stall  out  1  stall to execute; equals stall_in OR mem_busy
in_addr  in  REG_W  destination register from execute's registered output
in_val  in  DATA_W  ALU result from execute's registered output
is_mem_in  in  1  held instruction is a memory op (execute's registered is_mem)
mem_addr_in  in  ADDR_W  combinational memory address from execute
mem_val_in  in  DATA_W  combinational store data from execute
mem_write_in  in  1  combinational store flag from execute
fwd_valid  out  1  fwd_val is usable this cycle
fwd_addr  out  REG_W  destination of the held instruction
fwd_val  out  DATA_W  value of the held instruction
dbus_req_valid  out  1  memory request valid
dbus_req_ready  in  1  memory accepts the request
dbus_addr  out  ADDR_W  request address
dbus_wdata  out  DATA_W  store data
dbus_we  out  1  1 = store, 0 = load
dbus_rsp_valid  in  1  load data valid
dbus_rdata  in  DATA_W  load data
out_addr  out  REG_W  registered destination to writeback
out_val  out  DATA_W  registered value to writeback

Behaviour:
- Request capture: on each posedge with stall=0, latch mem_addr_in, mem_val_in and mem_write_in into req_addr, req_wdata and req_we. This aligns them with in_addr, in_val and is_mem_in, which execute latches on the same edge.
- FSM states: IDLE, REQ, WAIT. mem_busy is combinational:
  - IDLE: if is_mem_in, dbus_req_valid=1.
    - On ready, a store completes: mem_busy=0, stay IDLE.
    - On ready, a load: mem_busy=1, go to WAIT.
    - If not ready: mem_busy=1, go to REQ.
    - If is_mem_in=0: mem_busy=0.
  - REQ: dbus_req_valid=1 and mem_busy=1.
    - On ready, a store: mem_busy=0 that cycle, go to IDLE.
    - On ready, a load: go to WAIT.
  - WAIT: dbus_req_valid=0. mem_busy = ~dbus_rsp_valid. On rsp_valid, latch dbus_rdata into the result and go to IDLE.
- A response never arrives in its acceptance cycle. rsp_valid in IDLE or REQ is ignored.
- dbus_addr, dbus_wdata and dbus_we come from the req_* registers and stay stable while dbus_req_valid=1 until accepted.
- Result: fwd_val/out_val source is dbus_rdata on the completing WAIT cycle for loads, and in_val otherwise.
- fwd_addr = in_addr.
- fwd_valid = (~is_mem_in) OR (load completing this cycle). A store in_addr is 0 by convention and never forwards usefully.
- Output register on posedge:
  - stall=0: out_addr <= in_addr, out_val <= result. A completed store writes in_addr, which is expected to be 0.
  - stall=1 and stall_in=0 (self-induced stall): out_addr <= 0, out_val <= don't-care (bubble).
  - stall_in=1: hold.
- Downstream stall mid-access: an outstanding request continues. If a load completes while stall_in=1, the data is held in a result register, FSM goes to a DONE-hold state (merged into IDLE with a done flag), and no second request is issued. The data is released when stall_in drops.
- Reset (asynchronous, any time including mid-access):
  - FSM → IDLE, done flag cleared.
  - out_addr=0, out_val=0, dbus_req_valid=0, req_* = 0.
  - Any subsequent stale rsp_valid is ignored.
- No address alignment or width checking; word access only.

Decomposition:
- Shared package: FSM state encoding (IDLE/REQ/WAIT), REG_ZERO constant, default widths.
- One natural sub-module: dbus_master_fsm, which owns the request/response handshake and emits busy, done and rdata_latched.

Test Plan:
1. ALU passthrough: is_mem_in=0, in_addr=3, in_val=0x1234 → fwd_valid=1 the same cycle; out_addr=3, out_val=0x1234 after 1 edge; stall=0.
2. Load, ready immediate, response after 2 cycles with rdata=0xDEADBEEF, in_addr=5 → stall=1 for 2 cycles; out_addr=0 bubbles meanwhile; then out_addr=5, out_val=0xDEADBEEF; exactly one accepted request.
3. Store with ready low 3 cycles, addr=0x100, wdata=0xCAFE → dbus_req_valid held with stable addr/wdata/we=1; stall=1 for 3 cycles; completes on the ready cycle with zero extra cycles.
4. Downstream stall: stall_in=1 during a load response → out held; after stall_in drops, out_val=rdata; no duplicate request.
5. Async reset asserted in WAIT → outputs reset immediately; a later rsp_valid is ignored; the next ALU op passes through normally.
6. Back-to-back load then store → two requests in order; each address matches its instruction; no lost or repeated transactions.

Source files
------------

// File: rtl/stage_memory_pkg.sv
// Shared definitions for the memory pipeline stage: FSM encoding, constants and default widths.
package stage_memory_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REG_W_DEF  = 4;

  // Register address 0 never gets written back, so it doubles as the bubble marker.
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_t;

endpackage

// File: rtl/dbus_master_fsm.sv
// Data-bus handshake controller: issues one request per memory instruction, waits for load data,
// and parks a completed access (done) while the downstream stage is stalled.
module dbus_master_fsm
  import stage_memory_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              is_mem,
  input  logic              req_we,
  input  logic              dbus_req_ready,
  input  logic              dbus_rsp_valid,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic              dbus_req_valid,
  output logic              busy,
  output logic              done,
  output logic              load_fire,
  output logic [DATA_W-1:0] rdata_latched
);

  mem_state_t state;
  logic       done_q;

  assign done = done_q;

  always_comb begin
    dbus_req_valid = 1'b0;
    busy           = 1'b0;
    load_fire      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_mem && !done_q) begin
          dbus_req_valid = 1'b1;
          busy           = !(dbus_req_ready && req_we);
        end
      end
      ST_REQ: begin
        dbus_req_valid = 1'b1;
        busy           = !(dbus_req_ready && req_we);
      end
      ST_WAIT: begin
        busy      = !dbus_rsp_valid;
        load_fire = dbus_rsp_valid;
      end
      default: ;
    endcase
  end

  // A completion that lands while stall_in is high sets done, which suppresses
  // re-issuing the same instruction until writeback accepts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      done_q        <= 1'b0;
      rdata_latched <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (done_q) begin
            if (!stall_in) done_q <= 1'b0;
          end else if (is_mem) begin
            if (dbus_req_ready) begin
              if (req_we) done_q <= stall_in;
              else        state  <= ST_WAIT;
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dbus_req_ready) begin
            if (req_we) begin
              state  <= ST_IDLE;
              done_q <= stall_in;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dbus_rsp_valid) begin
            rdata_latched <= dbus_rdata;
            state         <= ST_IDLE;
            done_q        <= stall_in;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/stage_memory.sv
// Memory pipeline stage: drives the data bus for loads/stores, stalls execute while an access is
// outstanding, forwards the held result and registers the writeback pair.
module stage_memory
  import stage_memory_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  output logic              stall,
  input  logic [REG_W-1:0]  in_addr,
  input  logic [DATA_W-1:0] in_val,
  input  logic              is_mem_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] mem_val_in,
  input  logic              mem_write_in,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_addr,
  output logic [DATA_W-1:0] fwd_val,
  output logic              dbus_req_valid,
  input  logic              dbus_req_ready,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [DATA_W-1:0] dbus_wdata,
  output logic              dbus_we,
  input  logic              dbus_rsp_valid,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic [REG_W-1:0]  out_addr,
  output logic [DATA_W-1:0] out_val
);

  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_we;
  logic              mem_busy;
  logic              done;
  logic              load_fire;
  logic              load_held;
  logic [DATA_W-1:0] rdata_latched;
  logic [DATA_W-1:0] result;

  dbus_master_fsm #(
    .DATA_W(DATA_W)
  ) u_fsm (
    .clk           (clk),
    .rst           (rst),
    .stall_in      (stall_in),
    .is_mem        (is_mem_in),
    .req_we        (req_we),
    .dbus_req_ready(dbus_req_ready),
    .dbus_rsp_valid(dbus_rsp_valid),
    .dbus_rdata    (dbus_rdata),
    .dbus_req_valid(dbus_req_valid),
    .busy          (mem_busy),
    .done          (done),
    .load_fire     (load_fire),
    .rdata_latched (rdata_latched)
  );

  assign stall = stall_in | mem_busy;

  // Execute presents the memory fields combinationally; registering them here lines them
  // up with in_addr/in_val/is_mem_in, which execute registers on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_we    <= 1'b0;
    end else if (!stall) begin
      req_addr  <= mem_addr_in;
      req_wdata <= mem_val_in;
      req_we    <= mem_write_in;
    end
  end

  assign dbus_addr  = req_addr;
  assign dbus_wdata = req_wdata;
  assign dbus_we    = req_we;

  assign load_held = done & ~req_we;

  always_comb begin
    result = in_val;
    if (load_fire)      result = dbus_rdata;
    else if (load_held) result = rdata_latched;
  end

  assign fwd_valid = ~is_mem_in | load_fire | load_held;
  assign fwd_addr  = in_addr;
  assign fwd_val   = result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_addr <= '0;
      out_val  <= '0;
    end else if (!stall) begin
      out_addr <= in_addr;
      out_val  <= result;
    end else if (!stall_in) begin
      out_addr <= REG_W'(REG_ZERO);
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// Self-checking bench for stage_memory: acts as execute stage and data memory, and checks every
// cycle against an instruction-level model of what the stage must do.
module tb_stage_memory;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall_in;
  logic          stall;
  logic [RW-1:0] in_addr;
  logic [DW-1:0] in_val;
  logic          is_mem_in;
  logic [AW-1:0] mem_addr_in;
  logic [DW-1:0] mem_val_in;
  logic          mem_write_in;
  logic          fwd_valid;
  logic [RW-1:0] fwd_addr;
  logic [DW-1:0] fwd_val;
  logic          dbus_req_valid;
  logic          dbus_req_ready;
  logic [AW-1:0] dbus_addr;
  logic [DW-1:0] dbus_wdata;
  logic          dbus_we;
  logic          dbus_rsp_valid;
  logic [DW-1:0] dbus_rdata;
  logic [RW-1:0] out_addr;
  logic [DW-1:0] out_val;

  stage_memory #(.ADDR_W(AW), .DATA_W(DW), .REG_W(RW)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .stall(stall),
    .in_addr(in_addr), .in_val(in_val), .is_mem_in(is_mem_in),
    .mem_addr_in(mem_addr_in), .mem_val_in(mem_val_in), .mem_write_in(mem_write_in),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_val(fwd_val),
    .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_we(dbus_we),
    .dbus_rsp_valid(dbus_rsp_valid), .dbus_rdata(dbus_rdata),
    .out_addr(out_addr), .out_val(out_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] addr;
    logic [DW-1:0] val;
    bit            mem;
    bit            we;
    logic [AW-1:0] maddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } instr_t;

  instr_t prog[$];
  int errors = 0;
  int checks = 0;

  // instruction-level model state
  int  cur;
  bit  acc, comp, pending;
  int  cnt, rdy_cnt, hold_cnt, cyc;
  logic [RW-1:0] exp_out_addr;
  logic [DW-1:0] exp_out_val;
  bit  exp_val_known;
  // knobs
  int  k_rdy, k_lat, k_stall_pct;
  bit  k_stall_on_rsp, k_junk, force_stale;
  // observed accepted requests
  int            n_acc;
  logic [AW-1:0] acc_addr[$];
  bit            acc_we[$];

  function automatic instr_t mk_alu(logic [RW-1:0] a, logic [DW-1:0] v);
    instr_t i;
    i.addr = a; i.val = v; i.mem = 0; i.we = 0; i.maddr = $urandom; i.wdata = $urandom; i.rdata = '0;
    return i;
  endfunction

  function automatic instr_t mk_ld(logic [RW-1:0] a, logic [AW-1:0] ma, logic [DW-1:0] rd);
    instr_t i;
    i.addr = a; i.val = $urandom; i.mem = 1; i.we = 0; i.maddr = ma; i.wdata = $urandom; i.rdata = rd;
    return i;
  endfunction

  function automatic instr_t mk_st(logic [AW-1:0] ma, logic [DW-1:0] wd);
    instr_t i;
    i.addr = '0; i.val = $urandom; i.mem = 1; i.we = 1; i.maddr = ma; i.wdata = wd; i.rdata = '0;
    return i;
  endfunction

  function automatic instr_t get(int idx);
    if (idx < prog.size()) return prog[idx];
    return mk_alu('0, '0);
  endfunction

  task automatic step();
    instr_t ins, nxt;
    bit rsp, stl, rdy, exp_rv, acc_now, comp_now, done_v, exp_busy, exp_stall, exp_fv;
    logic [DW-1:0] exp_fval;
    @(negedge clk);
    cyc++;
    ins = get(cur);
    nxt = get(cur + 1);
    rsp = 0;
    if (pending) begin
      if (cnt > 0) cnt--;
      rsp = (cnt == 0);
    end else if (force_stale || (k_junk && $urandom_range(0, 3) == 0)) begin
      rsp = 1;
    end
    force_stale = 0;
    stl = ($urandom_range(0, 99) < k_stall_pct);
    if (k_stall_on_rsp && pending && rsp) hold_cnt = 2;
    if (hold_cnt > 0) begin stl = 1; hold_cnt--; end
    exp_rv = ins.mem && !acc;
    if (exp_rv) begin
      if (rdy_cnt == 0) rdy = 1;
      else begin rdy = 0; rdy_cnt--; end
    end else begin
      rdy = 1'($urandom_range(0, 1));
    end
    stall_in       = stl;
    dbus_req_ready = rdy;
    dbus_rsp_valid = rsp;
    dbus_rdata     = (pending && rsp) ? ins.rdata : $urandom;
    in_addr        = ins.addr;
    in_val         = ins.val;
    is_mem_in      = ins.mem;
    mem_addr_in    = nxt.maddr;
    mem_val_in     = nxt.wdata;
    mem_write_in   = nxt.we;
    #1;
    acc_now   = exp_rv && rdy;
    comp_now  = ins.mem && (ins.we ? acc_now : (pending && rsp));
    done_v    = comp || comp_now;
    exp_busy  = ins.mem && !done_v;
    exp_stall = stl || exp_busy;
    exp_fv    = !ins.mem || (!ins.we && done_v);
    exp_fval  = (ins.mem && !ins.we) ? ins.rdata : ins.val;

    checks++;
    if (stall !== exp_stall) begin errors++;
      $display("FAIL stall cyc=%0d got %b want %b", cyc, stall, exp_stall); end
    checks++;
    if (dbus_req_valid !== exp_rv) begin errors++;
      $display("FAIL req_valid cyc=%0d got %b want %b", cyc, dbus_req_valid, exp_rv); end
    checks++;
    if (fwd_valid !== exp_fv) begin errors++;
      $display("FAIL fwd_valid cyc=%0d got %b want %b", cyc, fwd_valid, exp_fv); end
    checks++;
    if (fwd_addr !== ins.addr) begin errors++;
      $display("FAIL fwd_addr cyc=%0d got %h want %h", cyc, fwd_addr, ins.addr); end
    if (exp_fv) begin
      checks++;
      if (fwd_val !== exp_fval) begin errors++;
        $display("FAIL fwd_val cyc=%0d got %h want %h", cyc, fwd_val, exp_fval); end
    end
    if (exp_rv) begin
      checks++;
      if (dbus_addr !== ins.maddr || dbus_we !== ins.we || (ins.we && dbus_wdata !== ins.wdata)) begin
        errors++;
        $display("FAIL dbus_req cyc=%0d got addr=%h we=%b wd=%h want addr=%h we=%b wd=%h",
                 cyc, dbus_addr, dbus_we, dbus_wdata, ins.maddr, ins.we, ins.wdata);
      end
    end
    if (dbus_req_valid && rdy) begin
      n_acc++;
      acc_addr.push_back(dbus_addr);
      acc_we.push_back(dbus_we);
    end

    @(posedge clk);
    if (acc_now) begin
      acc = 1;
      if (!ins.we) begin
        pending = 1;
        cnt = (k_lat == 0) ? $urandom_range(1, 3) : k_lat;
      end
    end
    if (comp_now) begin comp = 1; pending = 0; end
    if (!exp_stall) begin
      exp_out_addr  = ins.addr;
      exp_out_val   = exp_fval;
      exp_val_known = 1;
      cur++;
      acc = 0; comp = 0;
      rdy_cnt = (k_rdy < 0) ? $urandom_range(0, 3) : k_rdy;
    end else if (!stl) begin
      exp_out_addr  = '0;
      exp_val_known = 0;
    end
    #1;
    checks++;
    if (out_addr !== exp_out_addr) begin errors++;
      $display("FAIL out_addr cyc=%0d got %h want %h", cyc, out_addr, exp_out_addr); end
    if (exp_val_known) begin
      checks++;
      if (out_val !== exp_out_val) begin errors++;
        $display("FAIL out_val cyc=%0d got %h want %h", cyc, out_val, exp_out_val); end
    end
  endtask

  task automatic run_prog(input string name, input int budget);
    int n = 0;
    cur = 0; acc = 0; comp = 0; pending = 0; hold_cnt = 0;
    rdy_cnt = (k_rdy < 0) ? $urandom_range(0, 3) : k_rdy;
    while (cur < prog.size() && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (cur < prog.size()) begin errors++;
      $display("FAIL %s timeout retired %0d want %0d", name, cur, prog.size()); end
  endtask

  task automatic set_knobs(int rdy, int lat, int spct, bit son, bit junk);
    k_rdy = rdy; k_lat = lat; k_stall_pct = spct; k_stall_on_rsp = son; k_junk = junk;
  endtask

  task automatic test_reset();
    rst = 1; stall_in = 0; in_addr = '0; in_val = '0; is_mem_in = 0;
    mem_addr_in = '0; mem_val_in = '0; mem_write_in = 0;
    dbus_req_ready = 0; dbus_rsp_valid = 0; dbus_rdata = '0;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    #1;
    checks++;
    if (out_addr !== '0 || out_val !== '0) begin errors++;
      $display("FAIL reset_out got %h/%h want 0/0", out_addr, out_val); end
    checks++;
    if (dbus_req_valid !== 1'b0 || stall !== 1'b0 || dbus_addr !== '0 || dbus_we !== 1'b0) begin errors++;
      $display("FAIL reset_bus got rv=%b st=%b a=%h we=%b want 0", dbus_req_valid, stall, dbus_addr, dbus_we); end
    exp_out_addr = '0; exp_out_val = '0; exp_val_known = 1;
  endtask

  task automatic test_alu();
    set_knobs(0, 1, 0, 0, 0);
    prog = {mk_alu('0, '0), mk_alu(4'd3, 32'h1234), mk_alu(4'd7, 32'h55AA)};
    run_prog("alu", 20);
    checks++;
    if (cyc != 3) begin errors++;
      $display("FAIL alu_cycles got %0d want 3", cyc); end
  endtask

  task automatic test_load();
    int a0 = n_acc;
    set_knobs(0, 2, 0, 0, 0);
    prog = {mk_alu('0, '0), mk_ld(4'd5, 32'h200, 32'hDEADBEEF), mk_alu(4'd1, 32'h1)};
    run_prog("load", 30);
    checks++;
    if (n_acc - a0 != 1) begin errors++;
      $display("FAIL load_req_count got %0d want 1", n_acc - a0); end
  endtask

  task automatic test_store_wait();
    int c0;
    set_knobs(3, 1, 0, 0, 0);
    prog = {mk_alu('0, '0), mk_st(32'h100, 32'hCAFE), mk_alu(4'd2, 32'h22)};
    c0 = cyc;
    run_prog("store", 30);
    checks++;
    if (cyc - c0 != 6) begin errors++;
      $display("FAIL store_cycles got %0d want 6", cyc - c0); end
  endtask

  task automatic test_downstream_stall();
    int a0 = n_acc;
    set_knobs(0, 2, 0, 1, 0);
    prog = {mk_alu('0, '0), mk_ld(4'd9, 32'h300, 32'h0BADF00D), mk_alu(4'd4, 32'h44)};
    run_prog("dstall", 30);
    checks++;
    if (n_acc - a0 != 1) begin errors++;
      $display("FAIL dstall_req_count got %0d want 1", n_acc - a0); end
  endtask

  task automatic test_reset_mid_wait();
    set_knobs(0, 3, 0, 0, 0);
    prog = {mk_alu('0, '0), mk_ld(4'd6, 32'h400, 32'h12345678)};
    cur = 0; acc = 0; comp = 0; pending = 0; hold_cnt = 0; rdy_cnt = 0;
    repeat (3) step();
    #2;
    rst = 1; is_mem_in = 0; in_addr = '0; in_val = '0; dbus_rsp_valid = 0;
    #1;
    checks++;
    if (out_addr !== '0 || out_val !== '0 || dbus_req_valid !== 1'b0 || dbus_addr !== '0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got oa=%h ov=%h rv=%b a=%h st=%b want 0", out_addr, out_val, dbus_req_valid, dbus_addr, stall);
    end
    @(posedge clk);
    #2 rst = 0;
    exp_out_addr = '0; exp_out_val = '0; exp_val_known = 1;
    force_stale = 1;
    prog = {mk_alu('0, '0), mk_alu(4'd11, 32'hA11A), mk_alu(4'd12, 32'hB22B)};
    run_prog("post_reset", 20);
  endtask

  task automatic test_back_to_back();
    int a0 = n_acc;
    set_knobs(0, 1, 0, 0, 0);
    prog = {mk_alu('0, '0), mk_ld(4'd2, 32'h40, 32'h7777_0001), mk_st(32'h44, 32'h9999_0002),
            mk_alu(4'd8, 32'h88)};
    run_prog("b2b", 30);
    checks++;
    if (n_acc - a0 != 2) begin errors++;
      $display("FAIL b2b_req_count got %0d want 2", n_acc - a0); end
    else begin
      checks++;
      if (acc_addr[a0] !== 32'h40 || acc_we[a0] !== 1'b0 || acc_addr[a0+1] !== 32'h44 || acc_we[a0+1] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_order got %h/%b,%h/%b want 40/0,44/1", acc_addr[a0], acc_we[a0], acc_addr[a0+1], acc_we[a0+1]);
      end
    end
  endtask

  task automatic test_random();
    int a0 = n_acc;
    int nmem = 0;
    set_knobs(-1, 0, 25, 0, 1);
    prog = {mk_alu('0, '0)};
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0: prog.push_back(mk_alu(4'($urandom), $urandom));
        1: begin prog.push_back(mk_ld(4'($urandom_range(1, 15)), $urandom, $urandom)); nmem++; end
        default: begin prog.push_back(mk_st($urandom, $urandom)); nmem++; end
      endcase
    end
    run_prog("random", 2000);
    checks++;
    if (n_acc - a0 != nmem) begin errors++;
      $display("FAIL random_req_count got %0d want %0d", n_acc - a0, nmem); end
  endtask

  initial begin
    cyc = 0; n_acc = 0; force_stale = 0;
    test_reset();
    test_alu();
    test_load();
    test_store_wait();
    test_downstream_stall();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
